// File: rtl/modulator_pkg.sv
// ============================================================================
// Module  : modulator_pkg
// Brief   : Shared widths and frame-layout offsets for the AM/FM modulator
//           configuration path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package modulator_pkg;

    localparam int W_CTRL  = 8;
    localparam int W_FREC  = 24;
    localparam int W_IM    = 16;
    localparam int NBYTES  = 11;
    localparam int FRAME_W = 88;

    // Frame layout, first byte on the link occupies the top of the frame
    localparam int CTRL_MSB = 87;
    localparam int CTRL_LSB = 80;
    localparam int FMOD_MSB = 79;
    localparam int FMOD_LSB = 56;
    localparam int FPOR_MSB = 55;
    localparam int FPOR_LSB = 32;
    localparam int AM_MSB   = 31;
    localparam int AM_LSB   = 16;
    localparam int FM_MSB   = 15;
    localparam int FM_LSB   = 0;

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

`default_nettype wire

// File: rtl/byte_shift_chain.sv
// ============================================================================
// Module  : byte_shift_chain
// Brief   : NBYTES x DW register chain with parallel load and byte shift-in
//           at the LSB end; load has priority over shift.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_shift_chain #(
    parameter int DW     = 8,
    parameter int NBYTES = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [DW*NBYTES-1:0]   load_data_i,
    input  logic                   shift_i,
    input  logic [DW-1:0]          shift_data_i,
    output logic [DW*NBYTES-1:0]   chain_o
);

    localparam int FW = DW * NBYTES;

    logic [FW-1:0] chain_q;
    logic [FW-1:0] chain_d;

    always_comb begin
        chain_d = chain_q;
        if (load_i) begin
            chain_d = load_data_i;
        end else if (shift_i) begin
            chain_d = {chain_q[FW-DW-1:0], shift_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign chain_o = chain_q;

endmodule

`default_nettype wire

// File: rtl/regs_conf.sv
// ============================================================================
// Module  : regs_conf
// Brief   : Configuration register bank between the byte link and the DDS:
//           rx chain -> live config registers -> optional tx readback chain.
//           REGS_CONF_READBACK_EN enables the tx chain; otherwise txdw = 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_conf
    import modulator_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     rxdw,
    input  logic              shift_rxregs,
    input  logic              load_confregs,
    input  logic              load_txregs,
    input  logic              shift_txregs,
    output logic [DW-1:0]     txdw,
    output logic [W_CTRL-1:0] r_control,
    output logic [W_FREC-1:0] r_frec_mod,
    output logic [W_FREC-1:0] r_frec_por,
    output logic [W_IM-1:0]   r_im_am,
    output logic [W_IM-1:0]   r_im_fm
);

    frame_t w_rx_chain;
    frame_t conf_q;

    // The rx chain is never parallel-loaded; it only accumulates link bytes.
    byte_shift_chain #(
        .DW     (DW),
        .NBYTES (NBYTES)
    ) u_rx_chain (
        .clk          (clk),
        .rst          (rst),
        .load_i       (1'b0),
        .load_data_i  ('0),
        .shift_i      (shift_rxregs),
        .shift_data_i (rxdw),
        .chain_o      (w_rx_chain)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_q <= '0;
        end else if (load_confregs) begin
            conf_q <= w_rx_chain;
        end
    end

    assign r_control  = conf_q[CTRL_MSB:CTRL_LSB];
    assign r_frec_mod = conf_q[FMOD_MSB:FMOD_LSB];
    assign r_frec_por = conf_q[FPOR_MSB:FPOR_LSB];
    assign r_im_am    = conf_q[AM_MSB:AM_LSB];
    assign r_im_fm    = conf_q[FM_MSB:FM_LSB];

`ifdef REGS_CONF_READBACK_EN
    frame_t                    w_tx_chain;
    logic [FRAME_W-DW-1:0]     w_tx_tail_unused;

    byte_shift_chain #(
        .DW     (DW),
        .NBYTES (NBYTES)
    ) u_tx_chain (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_txregs),
        .load_data_i  (conf_q),
        .shift_i      (shift_txregs),
        .shift_data_i ('0),
        .chain_o      (w_tx_chain)
    );

    // Only the head byte leaves the block; the remainder just queues behind it.
    assign txdw             = w_tx_chain[FRAME_W-1 -: DW];
    assign w_tx_tail_unused = w_tx_chain[FRAME_W-DW-1:0];
`else
    logic w_tx_ctrl_unused;

    assign txdw             = '0;
    assign w_tx_ctrl_unused = load_txregs | shift_txregs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regs_conf.sv
// ============================================================================
// Module  : tb_regs_conf
// Brief   : Self-checking bench for regs_conf using a byte-array model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regs_conf;

`ifdef REGS_CONF_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxdw;
    logic        shift_rxregs, load_confregs, load_txregs, shift_txregs;
    logic [7:0]  txdw, r_control;
    logic [23:0] r_frec_mod, r_frec_por;
    logic [15:0] r_im_am, r_im_fm;

    int n_cmp = 0;
    int n_err = 0;

    // Model: index 0 is the oldest / first-on-the-link byte
    logic [7:0] m_rx   [11];
    logic [7:0] m_conf [11];
    logic [7:0] m_tx   [11];

    typedef struct {
        logic [87:0] frame;
        logic [7:0]  e_ctrl;
        logic [23:0] e_fmod;
        logic [23:0] e_fpor;
        logic [15:0] e_am;
        logic [15:0] e_fm;
    } vec_t;

    vec_t tbl [3];

    always #5 clk = ~clk;

    regs_conf #(.DW(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxdw          (rxdw),
        .shift_rxregs  (shift_rxregs),
        .load_confregs (load_confregs),
        .load_txregs   (load_txregs),
        .shift_txregs  (shift_txregs),
        .txdw          (txdw),
        .r_control     (r_control),
        .r_frec_mod    (r_frec_mod),
        .r_frec_por    (r_frec_por),
        .r_im_am       (r_im_am),
        .r_im_fm       (r_im_fm)
    );

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 11; i++) begin
            m_rx[i] = 8'h00; m_conf[i] = 8'h00; m_tx[i] = 8'h00;
        end
    endtask

    task automatic check_model();
        chk("model_txdw",     {16'h0, txdw},       RB ? {16'h0, m_tx[0]} : 24'h0);
        chk("model_control",  {16'h0, r_control},  {16'h0, m_conf[0]});
        chk("model_frec_mod", r_frec_mod,          {m_conf[1], m_conf[2], m_conf[3]});
        chk("model_frec_por", r_frec_por,          {m_conf[4], m_conf[5], m_conf[6]});
        chk("model_im_am",    {8'h0, r_im_am},     {8'h0, m_conf[7], m_conf[8]});
        chk("model_im_fm",    {8'h0, r_im_fm},     {8'h0, m_conf[9], m_conf[10]});
    endtask

    task automatic cycle(input logic srx, input logic [7:0] b, input logic lc,
                         input logic lt, input logic st);
        logic [7:0] nrx [11];
        logic [7:0] ntx [11];
        shift_rxregs = srx; rxdw = b; load_confregs = lc;
        load_txregs = lt; shift_txregs = st;
        @(posedge clk);
        nrx = m_rx;
        ntx = m_tx;
        if (srx) begin
            for (int i = 0; i < 10; i++) nrx[i] = m_rx[i+1];
            nrx[10] = b;
        end
        if (lt) begin
            ntx = m_conf;
        end else if (st) begin
            for (int i = 0; i < 10; i++) ntx[i] = m_tx[i+1];
            ntx[10] = 8'h00;
        end
        if (lc) m_conf = m_rx;
        m_rx = nrx;
        m_tx = ntx;
        #1;
        check_model();
        shift_rxregs = 1'b0; load_confregs = 1'b0;
        load_txregs = 1'b0; shift_txregs = 1'b0;
    endtask

    initial begin
        logic [87:0] fr;
        tbl[0] = '{88'h1919191919191919191919, 8'h19, 24'h191919, 24'h191919, 16'h1919, 16'h1919};
        tbl[1] = '{88'hA5123456ABCDEFDEADBEEF, 8'hA5, 24'h123456, 24'hABCDEF, 16'hDEAD, 16'hBEEF};
        tbl[2] = '{88'h0102030405060708090A0B, 8'h01, 24'h020304, 24'h050607, 16'h0809, 16'h0A0B};

        rst = 1'b0; rxdw = 8'h00;
        shift_rxregs = 1'b0; load_confregs = 1'b0;
        load_txregs = 1'b0; shift_txregs = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b1;

        // Load each table frame byte by byte, then commit
        for (int v = 0; v < 3; v++) begin
            fr = tbl[v].frame;
            for (int k = 0; k < 11; k++) cycle(1'b1, fr[87-8*k -: 8], 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("tbl_control",  {16'h0, r_control}, {16'h0, tbl[v].e_ctrl});
            chk("tbl_frec_mod", r_frec_mod,         tbl[v].e_fmod);
            chk("tbl_frec_por", r_frec_por,         tbl[v].e_fpor);
            chk("tbl_im_am",    {8'h0, r_im_am},    {8'h0, tbl[v].e_am});
            chk("tbl_im_fm",    {8'h0, r_im_fm},    {8'h0, tbl[v].e_fm});
        end

        // Readback of 01..0B then drained zero
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("rb_first", {16'h0, txdw}, RB ? 24'h01 : 24'h0);
        for (int k = 1; k <= 11; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            chk("rb_byte", {16'h0, txdw}, RB ? ((k < 11) ? 24'(k + 1) : 24'h0) : 24'h0);
        end

        // New rx bytes without commit leave config untouched
        for (int k = 0; k < 11; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        chk("hold_control",  {16'h0, r_control}, 24'h01);
        chk("hold_frec_mod", r_frec_mod,         24'h020304);
        chk("hold_im_fm",    {8'h0, r_im_fm},    24'h000A0B);

        // Load wins over shift on the tx chain
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
            chk("tx_load_prio", {16'h0, txdw}, RB ? 24'h01 : 24'h0);
        end

        // Shift together with commit: commit takes the pre-edge chain
        cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        // Commit together with tx load: tx takes the old config
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 99) < 60), 8'($urandom),
                  1'($urandom_range(0, 99) < 15),
                  1'($urandom_range(0, 99) < 15),
                  1'($urandom_range(0, 99) < 50));
        end

        // Asynchronous reset mid-run, away from any clock edge
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_txdw",     {16'h0, txdw},      24'h0);
        chk("arst_control",  {16'h0, r_control}, 24'h0);
        chk("arst_frec_mod", r_frec_mod,         24'h0);
        chk("arst_frec_por", r_frec_por,         24'h0);
        chk("arst_im_am",    {8'h0, r_im_am},    24'h0);
        chk("arst_im_fm",    {8'h0, r_im_fm},    24'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 50; n++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 99) < 20),
                  1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
